// File: rtl/fixed_point_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_mult_arbiter
// Brief    : Round-robin sharing of one pipelined signed Qm.n multiplier among
//            NUM_REQ requesters. Define FIXED_POINT_ARB_SAT_EN to saturate on
//            overflow; otherwise results wrap.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_point_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 32,
    parameter int Q            = 16,
    parameter int MULT_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [NUM_REQ*WIDTH-1:0]   rsp_data,
    output logic [NUM_REQ-1:0]         rsp_overflow
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int PW    = 2 * WIDTH;
    localparam int DEPTH = (MULT_LATENCY > 1) ? MULT_LATENCY - 1 : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q [NUM_REQ];
    state_t                   state_d [NUM_REQ];
    logic [IW-1:0]            ptr_q, ptr_d;
    logic [NUM_REQ-1:0]       eligible, grant_oh;
    logic [IW-1:0]            grant_idx;
    logic                     grant_any;
    logic [WIDTH-1:0]         s0_a, s0_b;
    logic [PW-1:0]            s0_prod;
    logic                     ret_valid;
    logic [IW-1:0]            ret_idx;
    logic [PW-1:0]            ret_prod;
    logic [PW-1:0]            ret_shift;
    logic                     ret_ovf;
    logic [WIDTH-1:0]         ret_data;
    logic [NUM_REQ*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]       rsp_ovf_q, rsp_ovf_d;

    // Grants are suppressed while reset is held so req_ready reads 0.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (state_q[i] == ST_IDLE) && !rst;
        end
    end

    always_comb begin : arb
        int cand;
        cand      = 0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_any && eligible[cand]) begin
                grant_any      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = IW'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        s0_a = '0;
        s0_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                s0_a = req_a[i*WIDTH +: WIDTH];
                s0_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Sign-extended operands make the low PW bits of the product the signed result.
    assign s0_prod = {{WIDTH{s0_a[WIDTH-1]}}, s0_a} * {{WIDTH{s0_b[WIDTH-1]}}, s0_b};

    generate
        if (MULT_LATENCY > 1) begin : g_pipe
            logic [DEPTH-1:0] vld_q, vld_d;
            logic [IW-1:0]    idx_q  [DEPTH];
            logic [IW-1:0]    idx_d  [DEPTH];
            logic [PW-1:0]    prod_q [DEPTH];
            logic [PW-1:0]    prod_d [DEPTH];

            always_comb begin
                vld_d[0]  = grant_any;
                idx_d[0]  = grant_idx;
                prod_d[0] = s0_prod;
                for (int k = 1; k < DEPTH; k++) begin
                    vld_d[k]  = vld_q[k-1];
                    idx_d[k]  = idx_q[k-1];
                    prod_d[k] = prod_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_q <= '0;
                else     vld_q <= vld_d;
            end

            always_ff @(posedge clk) begin
                idx_q  <= idx_d;
                prod_q <= prod_d;
            end

            assign ret_valid = vld_q[DEPTH-1];
            assign ret_idx   = idx_q[DEPTH-1];
            assign ret_prod  = prod_q[DEPTH-1];
        end else begin : g_nopipe
            assign ret_valid = grant_any;
            assign ret_idx   = grant_idx;
            assign ret_prod  = s0_prod;
        end
    endgenerate

    // Result fits only if every bit above the WIDTH-1 sign position matches it.
    assign ret_shift = $signed(ret_prod) >>> Q;
    assign ret_ovf   = !((&ret_shift[PW-1:WIDTH-1]) || !(|ret_shift[PW-1:WIDTH-1]));

`ifdef FIXED_POINT_ARB_SAT_EN
    assign ret_data = !ret_ovf          ? ret_shift[WIDTH-1:0] :
                      ret_shift[PW-1]   ? {1'b1, {(WIDTH-1){1'b0}}} :
                                          {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign ret_data = ret_shift[WIDTH-1:0];
`endif

    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: if (grant_oh[i])  state_d[i] = ST_BUSY;
                ST_BUSY: state_d[i] = ST_BUSY;
                ST_DONE: if (rsp_ready[i]) state_d[i] = ST_IDLE;
                default: state_d[i] = ST_IDLE;
            endcase
            // Retire wins over the grant so a single-stage pipeline lands in DONE.
            if (ret_valid && (ret_idx == IW'(i))) begin
                state_d[i]                   = ST_DONE;
                rsp_data_d[i*WIDTH +: WIDTH] = ret_data;
                rsp_ovf_d[i]                 = ret_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) state_q[i] <= ST_IDLE;
        end else begin
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = (state_q[i] == ST_DONE);
    end

    assign req_ready    = grant_oh;
    assign rsp_data     = rsp_data_q;
    assign rsp_overflow = rsp_ovf_q;

endmodule
`default_nettype wire

// File: doc/fixed_point_mult_arbiter.md
# fixed_point_mult_arbiter

Shares one pipelined signed fixed-point multiplier among `NUM_REQ` requesters using round-robin arbitration and per-requester valid/ready handshakes. All operands and results use one common format: `WIDTH` total bits including sign, and `Q` fractional bits. Each requester has one operation in flight at most and one result holding register, so the multiplier pipeline never stalls. The block sits between datapath sequencers and the shared multiply resource.

## Interface
- `NUM_REQ`, 4: number of requesters; must be at least 2.
- `WIDTH`, 32: operand and result width, sign bit included; at most 64.
- `Q`, 16: number of fractional bits; must be less than `WIDTH`.
- `MULT_LATENCY`, 3: multiplier pipeline depth in cycles; at least 1.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in NUM_REQ: requester i presents an operand pair.
- `req_ready` out NUM_REQ: grant; bit i is combinational.
- `req_a` in NUM_REQ*WIDTH: operand A; slice i is `[i*WIDTH +: WIDTH]`.
- `req_b` in NUM_REQ*WIDTH: operand B; sliced the same way as `req_a`.
- `rsp_valid` out NUM_REQ: result held for requester i.
- `rsp_ready` in NUM_REQ: requester i accepts its result.
- `rsp_data` out NUM_REQ*WIDTH: per-requester product in the same format as the operands.
- `rsp_overflow` out NUM_REQ: the product exceeded the range of the result format.

## Operation
- Each requester has its own state machine with three states:
  - IDLE → BUSY on a grant.
  - BUSY → DONE when its pipeline result retires.
  - DONE → IDLE on `rsp_valid & rsp_ready`.
- A requester is eligible when its state is IDLE and its `req_valid` is 1.
- Arbitration:
  - The round-robin pointer `ptr` resets to 0.
  - Search i = ptr, ptr+1, … (mod NUM_REQ) and grant the first eligible requester.
  - At most one grant per cycle; `req_ready` is one-hot or zero.
  - On a grant to g, `ptr <= (g+1) mod NUM_REQ`. With no grant, `ptr` holds.
- Handshake:
  - `req_ready[i]` does not depend on `rsp_ready`.
  - A transfer is `req_valid[i] & req_ready[i]`.
  - After asserting `req_valid`, the requester must hold it and the operands stable until the transfer.
- Pipeline:
  - Each stage carries a valid bit, a requester index, and data.
  - On retire, the result is written into `rsp_data[i]` and `rsp_overflow[i]`, and the state moves to DONE.
  - The pipeline cannot stall: the single-outstanding rule guarantees the holding register is free on retire.
- Arithmetic:
  - Full signed product P = A*B, 2*WIDTH bits.
  - R = P >>> Q, an arithmetic shift, so rounding is toward −∞.
  - Overflow when R lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - `rsp_overflow` is reported whether or not saturation is compiled in.
- `rsp_data` and `rsp_overflow` stay stable while `rsp_valid` is high and `rsp_ready` is low.

## Timing
- Reset values:
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_overflow`=0.
  - Internal: `ptr`=0, all states IDLE, all pipeline valids 0.
- Latency: a transfer in cycle T gives `rsp_valid` high in cycle T+MULT_LATENCY.
- Re-issue:
  - A response handshake in cycle t returns the requester to IDLE at t+1.
  - Its earliest next grant is t+1; there is no same-cycle recycle.
- Throughput: one grant per cycle in aggregate.
- Reset asserted mid-operation:
  - In-flight operations and held results are discarded immediately.
  - No `rsp_valid` is produced for them after reset is released.
- Simultaneous retire for requester i and `rsp_ready[i]` cannot occur, because `rsp_valid[i]` is 0 while requester i is BUSY.

## Configuration
- `FIXED_POINT_ARB_SAT_EN`:
  - Defined: an overflowing R is clamped to 2^(WIDTH−1)−1 (positive) or −2^(WIDTH−1) (negative).
  - Undefined: R wraps to its low WIDTH bits.
  - In both cases `rsp_overflow` is 1 on overflow.

## Test plan
Defaults throughout: WIDTH=32, Q=16, MULT_LATENCY=3.

- Basic product: req0 sends A=0x00018000 (1.5), B=0x00020000 (2.0) → `rsp_data[0]`=0x00030000 in cycle T+3, `rsp_overflow`=0.
- Negative operands and floor rounding:
  - A=0xFFFE8000 (−1.5), B=0x00020000 → 0xFFFD0000.
  - A=0xFFFFFFFF, B=0x00008000 → 0xFFFFFFFF.
- Overflow: A=0x7FFF0000, B=0x00020000 → `rsp_overflow`=1; data 0x7FFFFFFF with SAT_EN, 0xFFFE0000 without.
- Round-robin: all four requesters hold `req_valid`=1 and `rsp_ready`=1 → grants 0,1,2,3,0,1,… every cycle with no gaps; each sees a result 3 cycles after its grant.
- Backpressure: `rsp_ready[2]`=0 for 10 cycles → `rsp_data[2]` stays stable, `req_ready[2]` stays 0, and the other requesters keep being granted. Raising `rsp_ready` gives a handshake, then req2 is grantable the next cycle.
- Reset mid-flight: pulse `rst` one cycle after granting req1 → no `rsp_valid[1]` appears, all outputs are 0, and the first grant after reset goes to the lowest eligible index.
